// File: rtl/fp_pkg.sv
// Shared types and helpers for the streaming FP max/min reduction unit.
// Helpers take operands zero-extended to MAX_W so they serve any EXP_W/MAN_W.
package fp_pkg;

    localparam int DEF_EXP_W = 8;
    localparam int DEF_MAN_W = 23;
    localparam int DEF_IDX_W = 16;
    localparam int DEF_W     = 1 + DEF_EXP_W + DEF_MAN_W;
    localparam int MAX_W     = 64;

    localparam logic MODE_MAX = 1'b0;
    localparam logic MODE_MIN = 1'b1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        HOLD = 2'd2
    } state_t;

    // Exponent all ones with a nonzero fraction.
    function automatic logic is_nan(input logic [MAX_W-1:0] op, input int exp_w, input int man_w);
        logic exp_ones;
        logic man_nz;
        exp_ones = 1'b1;
        man_nz   = 1'b0;
        for (int i = 0; i < MAX_W; i++) begin
            if (i < man_w)
                man_nz = man_nz | op[i];
            else if (i < man_w + exp_w)
                exp_ones = exp_ones & op[i];
        end
        return exp_ones && man_nz;
    endfunction

    // Sign 0, exponent all ones, only the fraction MSB set.
    function automatic logic [MAX_W-1:0] canon_qnan(input int exp_w, input int man_w);
        logic [MAX_W-1:0] r;
        r = '0;
        for (int i = 0; i < MAX_W; i++)
            r[i] = (i >= man_w - 1) && (i < man_w + exp_w);
        return r;
    endfunction

endpackage

// File: rtl/fp_cmp_sel.sv
// Combinational candidate-vs-accumulator selection for max/min reduction,
// holding all ordering and NaN rules. take_cand=1 means the candidate wins.
module fp_cmp_sel
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic [W-1:0] acc,
    input  logic [W-1:0] cand,
    input  logic         mode,
    output logic         take_cand
);

    logic               acc_nan;
    logic               cand_nan;
    logic               acc_sign;
    logic               cand_sign;
    logic [W-2:0]       acc_mag;
    logic [W-2:0]       cand_mag;
    logic               cand_gt;
    logic               cand_lt;

    assign acc_nan   = is_nan(MAX_W'(acc), EXP_W, MAN_W);
    assign cand_nan  = is_nan(MAX_W'(cand), EXP_W, MAN_W);
    assign acc_sign  = acc[W-1];
    assign cand_sign = cand[W-1];
    assign acc_mag   = acc[W-2:0];
    assign cand_mag  = cand[W-2:0];

    // Sign-magnitude ordering: the positive side wins on differing signs,
    // magnitude order reverses for negatives. Bit-identical gives neither.
    always_comb begin
        cand_gt = 1'b0;
        cand_lt = 1'b0;
        if (acc_sign != cand_sign) begin
            cand_gt = !cand_sign;
            cand_lt = cand_sign;
        end else if (!cand_sign) begin
            cand_gt = cand_mag > acc_mag;
            cand_lt = cand_mag < acc_mag;
        end else begin
            cand_gt = cand_mag < acc_mag;
            cand_lt = cand_mag > acc_mag;
        end
    end

    // NaN rules override the mode: a NaN never displaces anything, and any
    // number displaces a NaN accumulator.
    always_comb begin
        take_cand = 1'b0;
        if (cand_nan)
            take_cand = 1'b0;
        else if (acc_nan)
            take_cand = 1'b1;
        else if (mode == MODE_MIN)
            take_cand = cand_lt;
        else
            take_cand = cand_gt;
    end

endmodule

// File: rtl/fp_stream_reduce.sv
// Streaming FP max/min reduction with argmax/argmin index and count.
// Optional macro FP_REDUCE_NAN_PROPAGATE_EN: any NaN yields canonical qNaN.
module fp_stream_reduce
    import fp_pkg::*;
#(
    parameter int EXP_W = 8,
    parameter int MAN_W = 23,
    parameter int IDX_W = 16,
    localparam int W    = 1 + EXP_W + MAN_W
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W-1:0]     out_data,
    output logic [IDX_W-1:0] out_index,
    output logic [IDX_W-1:0] out_count,
    output logic             out_all_nan
);

    localparam logic [IDX_W-1:0] IDX_MAX = '1;
    localparam logic [IDX_W-1:0] IDX_ONE = {{(IDX_W-1){1'b0}}, 1'b1};

    state_t            state_reg;
    state_t            state_next;
    logic [W-1:0]      acc_reg;
    logic [IDX_W-1:0]  idx_reg;
    logic [IDX_W-1:0]  cnt_reg;
    logic [IDX_W-1:0]  cnt_sat_next;
    logic              mode_reg;
    logic              all_nan_reg;
    logic              accept;
    logic              cand_nan;
    logic              take_cand;

`ifdef FP_REDUCE_NAN_PROPAGATE_EN
    localparam logic [MAX_W-1:0] QNAN_FULL = canon_qnan(EXP_W, MAN_W);
    localparam logic [W-1:0]     QNAN      = QNAN_FULL[W-1:0];
    logic nan_seen_reg;
`endif

    assign accept       = in_valid && in_ready;
    assign cand_nan     = is_nan(MAX_W'(in_data), EXP_W, MAN_W);
    assign cnt_sat_next = (cnt_reg == IDX_MAX) ? IDX_MAX : cnt_reg + IDX_ONE;

    fp_cmp_sel #(
        .EXP_W (EXP_W),
        .MAN_W (MAN_W)
    ) u_cmp (
        .acc       (acc_reg),
        .cand      (in_data),
        .mode      (mode_reg),
        .take_cand (take_cand)
    );

    always_ff @(posedge clk) begin
        if (rst)
            state_reg <= IDLE;
        else
            state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = in_last ? HOLD : ACC;
            ACC:     if (accept && in_last) state_next = HOLD;
            HOLD:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_reg != HOLD);
        out_valid = (state_reg == HOLD);
    end

    // The element being accepted sits at position cnt_reg, which saturates
    // together with the count.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_reg      <= '0;
            idx_reg      <= '0;
            cnt_reg      <= '0;
            mode_reg     <= MODE_MAX;
            all_nan_reg  <= 1'b0;
`ifdef FP_REDUCE_NAN_PROPAGATE_EN
            nan_seen_reg <= 1'b0;
`endif
        end else if (accept && state_reg == IDLE) begin
            mode_reg     <= mode;
            cnt_reg      <= IDX_ONE;
            idx_reg      <= '0;
            all_nan_reg  <= cand_nan;
`ifdef FP_REDUCE_NAN_PROPAGATE_EN
            acc_reg      <= cand_nan ? QNAN : in_data;
            nan_seen_reg <= cand_nan;
`else
            acc_reg      <= in_data;
`endif
        end else if (accept && state_reg == ACC) begin
            cnt_reg     <= cnt_sat_next;
            all_nan_reg <= all_nan_reg & cand_nan;
`ifdef FP_REDUCE_NAN_PROPAGATE_EN
            if (!nan_seen_reg) begin
                if (cand_nan) begin
                    acc_reg      <= QNAN;
                    idx_reg      <= cnt_reg;
                    nan_seen_reg <= 1'b1;
                end else if (take_cand) begin
                    acc_reg <= in_data;
                    idx_reg <= cnt_reg;
                end
            end
`else
            if (take_cand) begin
                acc_reg <= in_data;
                idx_reg <= cnt_reg;
            end
`endif
        end
    end

    assign out_data    = acc_reg;
    assign out_index   = idx_reg;
    assign out_count   = cnt_reg;
    assign out_all_nan = all_nan_reg;

endmodule

// File: tb/tb_fp_stream_reduce.sv
// Scoreboard bench for fp_stream_reduce (fp32, IDX_W=4 so saturation is reachable).
module tb_fp_stream_reduce;

    localparam int IDX_W = 4;
    localparam int W     = 32;

    typedef struct {
        logic [W-1:0]     data;
        logic [IDX_W-1:0] index;
        logic [IDX_W-1:0] count;
        logic             all_nan;
    } exp_t;

    logic             clk;
    logic             rst;
    logic             mode;
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     in_data;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [W-1:0]     out_data;
    logic [IDX_W-1:0] out_index;
    logic [IDX_W-1:0] out_count;
    logic             out_all_nan;

    exp_t         sb[$];
    logic [W-1:0] beats [0:19];
    int           n_vec;
    int           n_miss;

    fp_stream_reduce #(
        .EXP_W (8),
        .MAN_W (23),
        .IDX_W (IDX_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mode        (mode),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_index   (out_index),
        .out_count   (out_count),
        .out_all_nan (out_all_nan)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
        n_vec++;
        if (obs !== exp_v) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp_v);
        end
    endtask

    // Monitor: every output handshake pops one expected result.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_result", 64'(out_valid), 64'(0));
            end else begin
                exp_t e;
                e = sb.pop_front();
                $display("txn data=%h index=%0d count=%0d all_nan=%0d (exp %h/%0d/%0d/%0d)",
                         out_data, out_index, out_count, out_all_nan,
                         e.data, e.index, e.count, e.all_nan);
                check("out_data", 64'(out_data), 64'(e.data));
                check("out_index", 64'(out_index), 64'(e.index));
                check("out_count", 64'(out_count), 64'(e.count));
                check("out_all_nan", 64'(out_all_nan), 64'(e.all_nan));
            end
        end
    end

    // Drives beats[0:n-1]; mode is flipped after the first beat to show it is ignored.
    task automatic send(input logic mode_v, input int n, input logic [W-1:0] e_data,
                        input int e_idx, input int e_cnt, input logic e_nan);
        exp_t e;
        e.data    = e_data;
        e.index   = IDX_W'(e_idx);
        e.count   = IDX_W'(e_cnt);
        e.all_nan = e_nan;
        sb.push_back(e);
        for (int i = 0; i < n; i++) begin
            int k;
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = (i == n - 1);
            mode     = (i == 0) ? mode_v : ~mode_v;
            k = 0;
            @(negedge clk);
            if (i == 0) check("in_ready_first", 64'(in_ready), 64'(1));
            while (!in_ready && k < 20) begin
                @(negedge clk);
                k++;
            end
            if (!in_ready) check("in_ready_timeout", 64'(in_ready), 64'(1));
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("latency_out_valid", 64'(out_valid), 64'(1));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while (sb.size() != 0 && k < 50) begin
            @(negedge clk);
            k++;
        end
        check("drain_empty", 64'(sb.size()), 64'(0));
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_vec     = 0;
        n_miss    = 0;
        rst       = 1'b1;
        mode      = 1'b0;
        in_valid  = 1'b0;
        in_data   = '0;
        in_last   = 1'b0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_in_ready", 64'(in_ready), 64'(1));
        check("rst_out_data", 64'(out_data), 64'(0));
        check("rst_out_index", 64'(out_index), 64'(0));
        check("rst_out_count", 64'(out_count), 64'(0));
        check("rst_out_all_nan", 64'(out_all_nan), 64'(0));
        @(posedge clk);
        #1;

        // Basic max
        beats[0] = 32'h3F800000; beats[1] = 32'hC0400000; beats[2] = 32'h40000000;
        send(1'b0, 3, 32'h40000000, 2, 3, 1'b0); drain();

        // Signed zeros
        beats[0] = 32'h00000000; beats[1] = 32'h80000000;
        send(1'b1, 2, 32'h80000000, 1, 2, 1'b0); drain();
        send(1'b0, 2, 32'h00000000, 0, 2, 1'b0); drain();

        // Leading NaN, then infinity
        beats[0] = 32'h7FC00000; beats[1] = 32'h3F800000; beats[2] = 32'h7F800000;
`ifdef FP_REDUCE_NAN_PROPAGATE_EN
        send(1'b0, 3, 32'h7FC00000, 0, 3, 1'b0); drain();
`else
        send(1'b0, 3, 32'h7F800000, 2, 3, 1'b0); drain();
`endif

        // All NaN
        beats[0] = 32'h7FC00001; beats[1] = 32'h7FC00000;
`ifdef FP_REDUCE_NAN_PROPAGATE_EN
        send(1'b0, 2, 32'h7FC00000, 0, 2, 1'b1); drain();
`else
        send(1'b0, 2, 32'h7FC00001, 0, 2, 1'b1); drain();
`endif

        // Negative magnitudes reverse order; -inf is the minimum
        beats[0] = 32'hC0400000; beats[1] = 32'hC0000000;
        send(1'b0, 2, 32'hC0000000, 1, 2, 1'b0); drain();
        beats[0] = 32'h3F800000; beats[1] = 32'hFF800000; beats[2] = 32'hBF800000;
        send(1'b1, 3, 32'hFF800000, 1, 3, 1'b0); drain();

        // Ties under backpressure
        beats[0] = 32'h3F800000; beats[1] = 32'h3F800000;
        out_ready = 1'b0;
        send(1'b0, 2, 32'h3F800000, 0, 2, 1'b0);
        for (int c = 0; c < 5; c++) begin
            check("bp_in_ready", 64'(in_ready), 64'(0));
            check("bp_out_valid", 64'(out_valid), 64'(1));
            check("bp_out_data", 64'(out_data), 64'(32'h3F800000));
            check("bp_out_index", 64'(out_index), 64'(0));
            @(negedge clk);
        end
        out_ready = 1'b1;
        drain();
        beats[0] = 32'h40400000;
        send(1'b0, 1, 32'h40400000, 0, 1, 1'b0); drain();

        // Count/index saturation: 17 ascending elements
        for (int i = 0; i < 17; i++) beats[i] = 32'h3F800000 + 32'(i) * 32'h00100000;
        send(1'b0, 17, 32'h3F800000 + 32'd16 * 32'h00100000, 15, 15, 1'b0); drain();

        // Reset mid-vector
        beats[0] = 32'h3F800000; beats[1] = 32'h40800000;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_data  = beats[i];
            in_last  = 1'b0;
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_out_valid", 64'(out_valid), 64'(0));
        check("midrst_in_ready", 64'(in_ready), 64'(1));
        check("midrst_out_count", 64'(out_count), 64'(0));
        check("midrst_out_data", 64'(out_data), 64'(0));
        @(posedge clk);
        #1;
        beats[0] = 32'h40000000;
        send(1'b0, 1, 32'h40000000, 0, 1, 1'b0); drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
